// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 16 {A,B,C,D} vectors into two functions, samples both after a settle time and compares them
// Optional build macro: SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module truth_table_sweeper #(
    parameter int SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        f_ref,
    input  logic        f_sim,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_fail,
    output logic        fail_valid,
    output logic [15:0] truth_table
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    state_t     state;
    logic [3:0] idx, scnt;
    logic       miss, last;
    logic [4:0] cnt_nxt;
    assign {A, B, C, D} = idx;
    // Mismatch of the current vector, running count including it, and whether this sample ends the sweep
    always_comb begin
        miss    = f_ref != f_sim;
        cnt_nxt = mismatch_count + 5'(miss);
`ifdef SWEEP_STOP_ON_FAIL_EN
        last    = (idx == 4'hF) || miss;
`else
        last    = idx == 4'hF;
`endif
    end
    // Sequencer: start/clear, settle countdown, sample-and-compare, abort back to idle keeping partial results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            scnt           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            first_fail     <= '0;
            fail_valid     <= 1'b0;
            truth_table    <= '0;
        end else if (abort && busy) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                SETTLE: begin
                    if (scnt == 4'(SETTLE_CYC - 1)) state <= SAMPLE;
                    else scnt <= scnt + 4'd1;
                end
                SAMPLE: begin
                    truth_table[idx] <= f_sim;
                    if (miss) begin
                        mismatch_count <= cnt_nxt;
                        if (!fail_valid) begin
                            first_fail <= idx;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= cnt_nxt == 5'd0;
                    end else begin
                        idx   <= idx + 4'd1;
                        scnt  <= '0;
                        state <= SETTLE;
                    end
                end
                default: begin
                    if (start) begin
                        state          <= SETTLE;
                        idx            <= '0;
                        scnt           <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        mismatch_count <= '0;
                        first_fail     <= '0;
                        fail_valid     <= 1'b0;
                        truth_table    <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed and randomized sweeps checked against a vector-level reference model
module tb_truth_table_sweeper;
    localparam int S = 2;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [15:0] rt = '0, st = '0;
    logic A, B, C, D, busy, done, pass, fail_valid, f_ref, f_sim;
    logic [4:0] mc;
    logic [3:0] ff;
    logic [15:0] tt;
    logic q_start = 1'b0;
    logic qA, qB, qC, qD, q_busy, q_done, q_pass, q_fv;
    logic [4:0] q_mc;
    logic [3:0] q_ff;
    logic [15:0] q_tt;
    int ncmp = 0, nfail = 0;

    assign f_ref = rt[{A, B, C, D}];
    assign f_sim = st[{A, B, C, D}];

    truth_table_sweeper #(.SETTLE_CYC(S)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f_ref(f_ref), .f_sim(f_sim),
        .A(A), .B(B), .C(C), .D(D), .busy(busy), .done(done), .pass(pass),
        .mismatch_count(mc), .first_fail(ff), .fail_valid(fail_valid), .truth_table(tt)
    );

    truth_table_sweeper #(.SETTLE_CYC(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(q_start), .abort(1'b0), .f_ref(qA), .f_sim(qA),
        .A(qA), .B(qB), .C(qC), .D(qD), .busy(q_busy), .done(q_done), .pass(q_pass),
        .mismatch_count(q_mc), .first_fail(q_ff), .fail_valid(q_fv), .truth_table(q_tt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected results after the first `upto` vectors have been sampled
    task automatic model(input logic [15:0] r, input logic [15:0] s, input int upto,
                         output int cnt, output logic [15:0] t, output int f, output logic v, output int last);
        cnt = 0; t = '0; f = 0; v = 1'b0; last = upto - 1;
        for (int i = 0; i < upto; i++) begin
            t[i] = s[i];
            if (r[i] != s[i]) begin
                cnt++;
                if (!v) begin f = i; v = 1'b1; end
`ifdef SWEEP_STOP_ON_FAIL_EN
                last = i;
                break;
`endif
            end
        end
    endtask

    function automatic logic [15:0] team_f();
        logic [15:0] t;
        for (int i = 0; i < 16; i++) begin
            logic a, b, c, d;
            {a, b, c, d} = 4'(i);
            t[i] = (b & d) | (c & d) | (~a & ~c & ~d) | (b & c & ~d);
        end
        return t;
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic sweep(input logic [15:0] r, input logic [15:0] s, input string tag);
        int cnt, f, last, n;
        logic [15:0] t;
        logic v;
        rt = r; st = s;
        model(r, s, 16, cnt, t, f, v, last);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({tag, ".busy0"}, {busy, done, A, B, C, D}, 6'b100000);
        wait_done(n);
        chk({tag, ".lat"}, n, (last + 1) * (S + 1));
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".mc"}, mc, cnt);
        chk({tag, ".ff"}, ff, f);
        chk({tag, ".fv"}, fail_valid, v);
        chk({tag, ".pass"}, pass, cnt == 0);
        chk({tag, ".tt"}, tt, t);
        chk({tag, ".abcd"}, {A, B, C, D}, last);
    endtask

    initial begin
        logic [15:0] fv, r, s, t;
        int n, cnt, f, last;
        logic v;
        fv = team_f();
        #1 chk("reset", {A, B, C, D, busy, done, pass, fail_valid, mc, ff, tt}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        sweep(fv, fv, "equiv");
        chk("equiv.tt_const", tt, 16'hE8F9);

        sweep(fv | 16'h0104, fv, "two_miss");
`ifdef SWEEP_STOP_ON_FAIL_EN
        chk("two_miss.mc_const", {mc, ff, tt}, {5'd1, 4'd2, 16'h0001});
`else
        chk("two_miss.mc_const", {mc, ff}, {5'd2, 4'd2});
`endif

        for (int k = 0; k < 6; k++) begin
            s = 16'($urandom);
            r = (k % 2 == 0) ? s ^ (16'($urandom) & 16'($urandom) & 16'($urandom)) : 16'($urandom);
            sweep(r, s, $sformatf("rand%0d", k));
        end

        // abort during vector 5 settle, partial results kept
        s = 16'($urandom);
`ifdef SWEEP_STOP_ON_FAIL_EN
        r = s ^ (16'($urandom) & 16'hFFE0);
`else
        r = s ^ 16'($urandom);
`endif
        rt = r; st = s;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (5 * (S + 1)) @(negedge clk);
        chk("abort.pre", {busy, A, B, C, D}, 5'b10101);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        model(r, s, 5, cnt, t, f, v, last);
        chk("abort.state", {busy, done, pass, A, B, C, D}, 0);
        chk("abort.mc", mc, cnt);
        chk("abort.tt", tt, t);
        chk("abort.fv", {fail_valid, ff}, {v, 4'(f)});
        sweep(fv, fv, "post_abort");

        // asynchronous reset mid-sweep
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (9 * (S + 1)) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("mid_reset", {A, B, C, D, busy, done, pass, fail_valid, mc, ff, tt}, 0);
        @(negedge clk) rst_n = 1'b1;
        sweep(fv | 16'h0104, fv, "post_reset");

        // start held through a whole sweep
        rt = fv; st = fv;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        wait_done(n);
        chk("held.lat", n, 16 * (S + 1));
        @(negedge clk);
        chk("held.restart", {done, busy, A, B, C, D, mc, tt}, {2'b01, 4'd0, 5'd0, 16'd0});
        start = 1'b0;
        wait_done(n);
        chk("held.done2", {done, pass}, 2'b11);

        // SETTLE_CYC=1 instance, f = A
        @(negedge clk) q_start = 1'b1;
        @(negedge clk) q_start = 1'b0;
        n = 0;
        while (!q_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("s1.lat", n, 32);
        chk("s1.tt", q_tt, 16'hFF00);
        chk("s1.pass", {q_pass, q_fv, q_mc, q_busy}, {2'b10, 5'd0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
